// File: rtl/inst_trace_fifo_pkg.sv
// Shared types and widths for the instruction-trace FIFO.
// INST_TRACE_FIFO_STAMP_EN adds a commit stamp field to each entry.
package inst_trace_fifo_pkg;

   localparam int PC_W    = 32;
   localparam int DATA_W  = 32;
   localparam int REG_W   = 5;
   localparam int STAMP_W = 32;

   typedef struct packed {
`ifdef INST_TRACE_FIFO_STAMP_EN
      logic [STAMP_W-1:0] stamp;
`endif
      logic [PC_W-1:0]    pc;
      logic [REG_W-1:0]   waddr;
      logic [DATA_W-1:0]  wdata;
      logic               wen;
   } inst_trace_entry_t;

endpackage

// File: rtl/inst_trace_fifo_mem.sv
// Entry storage: one write port, one asynchronous read port, async clear to zero.
module trace_fifo_mem
   import inst_trace_fifo_pkg::*;
#(
   parameter int p_depth = 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_wen,
   input  logic [$clog2(p_depth)-1:0] i_waddr,
   input  inst_trace_entry_t          i_wdata,
   input  logic [$clog2(p_depth)-1:0] i_raddr,
   output inst_trace_entry_t          o_rdata
);

   inst_trace_entry_t [p_depth-1:0] r_mem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       r_mem          <= '0;
      else if (i_wen) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_trace_fifo.sv
// Commit-trace FIFO: lossy on overflow with a sticky flag and saturating drop count.
// INST_TRACE_FIFO_STAMP_EN adds out_stamp, a per-commit sequence number.
module inst_trace_fifo
   import inst_trace_fifo_pkg::*;
#(
   parameter int p_depth     = 8,
   parameter int p_drop_bits = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_val,
   input  logic [PC_W-1:0]          trace_pc,
   input  logic [REG_W-1:0]         trace_waddr,
   input  logic [DATA_W-1:0]        trace_wdata,
   input  logic                     trace_wen,
   output logic                     out_val,
   input  logic                     out_rdy,
   output logic [PC_W-1:0]          out_pc,
   output logic [REG_W-1:0]         out_waddr,
   output logic [DATA_W-1:0]        out_wdata,
   output logic                     out_wen,
`ifdef INST_TRACE_FIFO_STAMP_EN
   output logic [STAMP_W-1:0]       out_stamp,
`endif
   output logic [$clog2(p_depth):0] occupancy,
   output logic                     overflow,
   output logic [p_drop_bits-1:0]   drop_cnt,
   input  logic                     clr_overflow
);

   localparam int PTR_W = $clog2(p_depth);
   localparam int OCC_W = PTR_W + 1;

   logic [PTR_W-1:0]       r_wptr, r_rptr;
   logic [OCC_W-1:0]       r_occ;
   logic                   r_overflow;
   logic [p_drop_bits-1:0] r_drop_cnt;
   logic                   w_full, w_pop, w_push, w_drop;
   inst_trace_entry_t      w_wr, w_rd;

   assign out_val = (r_occ != '0);
   assign w_full  = (r_occ == OCC_W'(p_depth));
   assign w_pop   = out_val && out_rdy;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign w_push  = trace_val && (!w_full || w_pop);
   assign w_drop  = trace_val && w_full && !w_pop;

`ifdef INST_TRACE_FIFO_STAMP_EN
   logic [STAMP_W-1:0] r_stamp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           r_stamp <= '0;
      else if (trace_val) r_stamp <= r_stamp + STAMP_W'(1);
   end

   assign w_wr.stamp = r_stamp;
   assign out_stamp  = w_rd.stamp;
`endif
   assign w_wr.pc    = trace_pc;
   assign w_wr.waddr = trace_waddr;
   assign w_wr.wdata = trace_wdata;
   assign w_wr.wen   = trace_wen;

   trace_fifo_mem #(.p_depth(p_depth)) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_wen   (w_push),
      .i_waddr (r_wptr),
      .i_wdata (w_wr),
      .i_raddr (r_rptr),
      .o_rdata (w_rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
         else if (w_pop && !w_push) r_occ <= r_occ - OCC_W'(1);
      end
   end

   // A drop coinciding with a clear restarts the count at one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (clr_overflow)     r_drop_cnt <= p_drop_bits'(1);
         else if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + p_drop_bits'(1);
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

   assign out_pc    = w_rd.pc;
   assign out_waddr = w_rd.waddr;
   assign out_wdata = w_rd.wdata;
   assign out_wen   = w_rd.wen;
   assign occupancy = r_occ;
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

`ifndef SYNTHESIS
   function automatic string linetrace();
      return $sformatf("occ=%0d pc=%08h drops=%0d", r_occ, w_rd.pc, r_drop_cnt);
   endfunction
`endif

endmodule

// File: tb/tb_inst_trace_fifo.sv
// Scoreboard bench for inst_trace_fifo: directed pushes feed an expected queue,
// a forked monitor checks every popped entry against it.
module tb_inst_trace_fifo;
   import inst_trace_fifo_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trace_val = 1'b0;
   logic [31:0] trace_pc = '0;
   logic [4:0]  trace_waddr = '0;
   logic [31:0] trace_wdata = '0;
   logic        trace_wen = 1'b0;
   logic        out_rdy = 1'b0;
   logic        clr_overflow = 1'b0;

   logic        out_val, out_wen, overflow;
   logic [31:0] out_pc, out_wdata;
   logic [4:0]  out_waddr;
   logic [3:0]  occupancy;
   logic [15:0] drop_cnt;

   logic        s_val, s_wen, s_ovf;
   logic [31:0] s_pc, s_wdata;
   logic [4:0]  s_waddr;
   logic [3:0]  s_occ;
   logic [3:0]  s_drop;
`ifdef INST_TRACE_FIFO_STAMP_EN
   logic [31:0] out_stamp, s_stamp;
`endif

   always #5 clk = ~clk;

   inst_trace_fifo #(.p_depth(8), .p_drop_bits(16)) dut (
      .clk(clk), .rst(rst), .trace_val(trace_val), .trace_pc(trace_pc),
      .trace_waddr(trace_waddr), .trace_wdata(trace_wdata), .trace_wen(trace_wen),
      .out_val(out_val), .out_rdy(out_rdy), .out_pc(out_pc), .out_waddr(out_waddr),
      .out_wdata(out_wdata), .out_wen(out_wen),
`ifdef INST_TRACE_FIFO_STAMP_EN
      .out_stamp(out_stamp),
`endif
      .occupancy(occupancy), .overflow(overflow), .drop_cnt(drop_cnt),
      .clr_overflow(clr_overflow)
   );

   // Narrow drop counter twin, fed the same stimulus, for saturation.
   inst_trace_fifo #(.p_depth(8), .p_drop_bits(4)) dut_sat (
      .clk(clk), .rst(rst), .trace_val(trace_val), .trace_pc(trace_pc),
      .trace_waddr(trace_waddr), .trace_wdata(trace_wdata), .trace_wen(trace_wen),
      .out_val(s_val), .out_rdy(out_rdy), .out_pc(s_pc), .out_waddr(s_waddr),
      .out_wdata(s_wdata), .out_wen(s_wen),
`ifdef INST_TRACE_FIFO_STAMP_EN
      .out_stamp(s_stamp),
`endif
      .occupancy(s_occ), .overflow(s_ovf), .drop_cnt(s_drop),
      .clr_overflow(clr_overflow)
   );

   int                n_cmp = 0;
   int                n_fail = 0;
   int unsigned       tb_stamp = 0;
   inst_trace_entry_t exp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [4:0] wa,
                       input logic [31:0] wd, input logic we, input bit acc);
      inst_trace_entry_t e;
      e = '0;
      e.pc = pc; e.waddr = wa; e.wdata = wd; e.wen = we;
`ifdef INST_TRACE_FIFO_STAMP_EN
      e.stamp = tb_stamp;
`endif
      tb_stamp++;
      if (acc) exp_q.push_back(e);
      trace_val = 1'b1; trace_pc = pc; trace_waddr = wa; trace_wdata = wd; trace_wen = we;
      cyc();
      trace_val = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      out_rdy = 1'b1;
      while (occupancy != 0 && n < 40) begin
         cyc();
         n++;
      end
      out_rdy = 1'b0;
      chk({name, "_occ"}, 128'(occupancy), 128'(0));
      chk({name, "_q_empty"}, 128'(exp_q.size()), 128'(0));
   endtask

   task automatic monitor();
      inst_trace_entry_t got, e;
      forever begin
         @(negedge clk);
         if (rst && out_val && out_rdy) begin
            got = '0;
            got.pc = out_pc; got.waddr = out_waddr; got.wdata = out_wdata; got.wen = out_wen;
`ifdef INST_TRACE_FIFO_STAMP_EN
            got.stamp = out_stamp;
`endif
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 128'(got), 128'(1'b0) - 128'(1));
            end else begin
               e = exp_q.pop_front();
               chk("pop_entry", 128'(got), 128'(e));
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      fork
         monitor();
      join_none

      #7;
      chk("rst_out_val",   128'(out_val),   128'(0));
      chk("rst_occ",       128'(occupancy), 128'(0));
      chk("rst_overflow",  128'(overflow),  128'(0));
      chk("rst_drop_cnt",  128'(drop_cnt),  128'(0));
      chk("rst_out_pc",    128'(out_pc),    128'(0));
      rst = 1'b1;
      cyc();

      // Single entry
      push(32'h200, 5'd3, 32'hDEAD, 1'b1, 1'b1);
      chk("single_val",   128'(out_val),   128'(1));
      chk("single_pc",    128'(out_pc),    128'(32'h200));
      chk("single_wdata", 128'(out_wdata), 128'(32'hDEAD));
      chk("single_occ",   128'(occupancy), 128'(1));
      out_rdy = 1'b1;
      cyc();
      out_rdy = 1'b0;
      chk("single_pop_occ", 128'(occupancy), 128'(0));

      // Fill then overflow by three
      for (int i = 0; i < 8; i++) push(32'h1000 + 32'(4*i), 5'(i), 32'(i), 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) push(32'h1F00 + 32'(4*i), 5'd9, 32'hBAD, 1'b0, 1'b0);
      chk("fill_occ",      128'(occupancy), 128'(8));
      chk("fill_overflow", 128'(overflow),  128'(1));
      chk("fill_drop_cnt", 128'(drop_cnt),  128'(3));

      // Full with simultaneous push and pop
      out_rdy = 1'b1;
      push(32'h2000, 5'd7, 32'h77, 1'b0, 1'b1);
      out_rdy = 1'b0;
      chk("pushpop_occ",  128'(occupancy), 128'(8));
      chk("pushpop_drop", 128'(drop_cnt),  128'(3));
      drain("drain1");

      // Drop and clear in the same cycle, then saturation
      for (int i = 0; i < 8; i++) push(32'h3000 + 32'(4*i), 5'd1, 32'(100 + i), 1'b1, 1'b1);
      clr_overflow = 1'b1;
      push(32'h3F00, 5'd2, 32'h0, 1'b1, 1'b0);
      clr_overflow = 1'b0;
      chk("clrdrop_overflow", 128'(overflow), 128'(1));
      chk("clrdrop_cnt",      128'(drop_cnt), 128'(1));
      chk("clrdrop_cnt_sat",  128'(s_drop),   128'(1));
      clr_overflow = 1'b1;
      cyc();
      clr_overflow = 1'b0;
      chk("clr_overflow", 128'(overflow), 128'(0));
      chk("clr_cnt",      128'(drop_cnt), 128'(0));
      for (int i = 0; i < 20; i++) push(32'h3E00, 5'd0, 32'h0, 1'b0, 1'b0);
      chk("drops20_cnt",      128'(drop_cnt), 128'(20));
      chk("drops20_sat_cnt",  128'(s_drop),   128'(15));
      chk("drops20_overflow", 128'(overflow), 128'(1));
      chk("drops20_occ",      128'(occupancy), 128'(8));

      // Async reset mid-drain
      out_rdy = 1'b1;
      cyc(); cyc(); cyc();
      out_rdy = 1'b0;
      chk("middrain_occ", 128'(occupancy), 128'(5));
      #2 rst = 1'b0;
      #1;
      chk("arst_out_val",  128'(out_val),   128'(0));
      chk("arst_occ",      128'(occupancy), 128'(0));
      chk("arst_overflow", 128'(overflow),  128'(0));
      chk("arst_drop_cnt", 128'(drop_cnt),  128'(0));
      exp_q.delete();
      tb_stamp = 0;
      #3 rst = 1'b1;
      cyc();
      push(32'h4000, 5'd4, 32'h4444, 1'b1, 1'b1);
      chk("postrst_occ", 128'(occupancy), 128'(1));
      chk("postrst_pc",  128'(out_pc),    128'(32'h4000));
      drain("drain2");

      // Stamp sequence after a fresh reset (stamps only checked with the feature built)
      rst = 1'b0;
      #1;
      exp_q.delete();
      tb_stamp = 0;
      rst = 1'b1;
      cyc();
      for (int i = 0; i < 10; i++) push(32'h5000 + 32'(4*i), 5'd5, 32'(i), 1'b1, i < 8);
      drain("drain3");
      push(32'h6000, 5'd6, 32'h66, 1'b1, 1'b1);
      drain("drain4");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_trace_fifo.md
# inst_trace_fifo

Buffers the per-commit instruction trace published by the processor top (pc, waddr, wdata, wen, val) into a FIFO and drains it over a val/rdy stream to a host or debug consumer. It sits directly downstream of the processor's inst_trace notification port, which has no backpressure. When the buffer is full it drops entries, counts them, and reports the drops so the consumer can detect a gap in the trace.

## Interface
- p_depth, 8, number of entries; power of two, at least 2
- p_drop_bits, 16, width of the drop counter
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- trace_val  in  1  commit notification valid; no backpressure
- trace_pc  in  32  committed pc
- trace_waddr  in  5  destination register
- trace_wdata  in  32  writeback data
- trace_wen  in  1  register write enable
- out_val  out  1  head entry valid
- out_rdy  in  1  consumer ready
- out_pc / out_waddr / out_wdata / out_wen  out  32/5/32/1  head entry fields
- occupancy  out  $clog2(p_depth)+1  current entry count
- overflow  out  1  sticky; set by any drop
- drop_cnt  out  p_drop_bits  saturating count of dropped entries
- clr_overflow  in  1  clears overflow and drop_cnt

## Operation
- Push: trace_val && (!full || pop). A full FIFO accepts a push in the same cycle as a pop. Occupancy is unchanged.
- Pop: out_val && out_rdy. out_val = (occupancy != 0).
- Drop: trace_val && full && !pop.
  - drop_cnt increments and saturates at all-ones.
  - overflow is set.
  - Storage and pointers are unchanged.
- Clear: clr_overflow zeroes drop_cnt and overflow. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Pointers: read and write pointers are log2(p_depth) bits and wrap modulo p_depth. Full/empty is decided from occupancy, not from pointer equality.
- Output fields come straight from the storage entry at the read pointer. When out_val=0 their value is don't-care, but they carry no X after reset.
- Simultaneous push and pop while empty is impossible, because pop requires out_val.
- rst is asserted asynchronously:
  - Pointers, occupancy, overflow and drop_cnt go to 0 immediately.
  - out_val goes to 0.
  - Any buffered entries are discarded.
- Reset values: out_val=0, occupancy=0, overflow=0, drop_cnt=0. Data outputs reflect storage initialised to 0.

## Timing
- Push to out_val: 1 cycle. There is no combinational bypass from trace_* to out_*.
- out_rdy has no combinational path to any output.
- trace_val has no combinational path to any output.
- out_val/out_* must hold stable while out_val && !out_rdy.
- occupancy, overflow and drop_cnt are registered and update the cycle after the event.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- INST_TRACE_FIFO_STAMP_EN defined:
  - Adds output out_stamp [31:0].
  - Keeps a 32-bit commit counter, reset to 0, that increments on every trace_val, whether accepted or dropped.
  - Each accepted entry stores the counter value before the increment. The consumer can therefore locate a gap exactly.
  - The counter wraps at 2^32.
- Not defined: no out_stamp port and no counter. Behaviour is otherwise identical.

## Structure
- The shared package holds:
  - typedef inst_trace_entry_t: pc, waddr, wdata, wen, plus stamp under the macro.
  - Width constants: 32 for pc/data, 5 for register address.
- Sub-module trace_fifo_mem:
  - p_depth x entry register array, one write port and one asynchronous read port.
  - Reset to zero asynchronously.
- The top holds pointers, occupancy, drop and overflow logic, and the stamp counter.
- Linetrace function outputs occupancy, head pc and the drop count, guarded by `ifndef SYNTHESIS`.

## Test plan
- Single entry: trace_val with pc=0x200, waddr=3, wdata=0xDEAD, wen=1, out_rdy=0 -> next cycle out_val=1, out_pc=0x200, out_wdata=0xDEAD, occupancy=1. Raise out_rdy -> occupancy=0 the following cycle.
- Fill to p_depth=8 with out_rdy=0, then push 3 more -> occupancy=8, overflow=1, drop_cnt=3. Drain -> pcs emerge in order, the first 8 only.
- Full with push and pop in the same cycle -> occupancy stays 8, drop_cnt unchanged, the new entry appears last.
- Drop in the same cycle as clr_overflow -> overflow=1, drop_cnt=1. Drive p_drop_bits=4 with 20 drops -> drop_cnt=15.
- Async rst mid-drain (occupancy=5) -> out_val=0 before the next clk edge. After release, a push gives occupancy=1 and the old entries are gone.
- INST_TRACE_FIFO_STAMP_EN: 10 pushes into depth 8 with no drain -> drained stamps 0..7; the next accepted entry after draining carries stamp 10.
